// File: rtl/atm_bank_pkg.sv
// Shared types and defaults for the ATM bank responder: op/status encodings,
// FSM states and the per-account table entry.
package atm_bank_pkg;

  localparam int BAL_W        = 8;
  localparam int ACCT_W       = 5;
  localparam int PIN_W        = 4;
  localparam int FAIL_W       = 2;
  localparam int DEF_NUM_ACCT = 32;
  localparam int DEF_MAX_TRIES = 3;
  localparam logic [BAL_W-1:0] DEF_INIT_BAL    = BAL_W'(50);
  localparam logic [PIN_W-1:0] DEF_DEFAULT_PIN = 4'b1111;

  typedef enum logic [2:0] {
    OP_VERIFY     = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_CHANGE_PIN = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_BAD_PIN      = 3'd1,
    ST_LOCKED       = 3'd2,
    ST_INSUFFICIENT = 3'd3,
    ST_OVERFLOW     = 3'd4,
    ST_BAD_OP       = 3'd5,
    ST_BAD_ACCT     = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [BAL_W-1:0]  balance;
    logic [PIN_W-1:0]  pin;
    logic [FAIL_W-1:0] fails;
    logic              locked;
  } acct_entry_t;

  function automatic acct_entry_t make_init_entry(input logic [BAL_W-1:0] bal,
                                                  input logic [PIN_W-1:0] pin);
    acct_entry_t e;
    e.balance = bal;
    e.pin     = pin;
    e.fails   = '0;
    e.locked  = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/atm_acct_table.sv
// Per-account state storage: flop array initialised on reset, with one
// registered read port and one write port.
module atm_acct_table
  import atm_bank_pkg::*;
#(
  parameter int               NUM_ACCT    = DEF_NUM_ACCT,
  parameter logic [BAL_W-1:0] INIT_BAL    = DEF_INIT_BAL,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = DEF_DEFAULT_PIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACCT_W-1:0] raddr,
  output acct_entry_t       rdata,
  input  logic              we,
  input  logic [ACCT_W-1:0] waddr,
  input  acct_entry_t       wdata
);

  localparam acct_entry_t INIT_ENTRY = make_init_entry(INIT_BAL, DEFAULT_PIN);

  acct_entry_t mem [NUM_ACCT];

  logic raddr_ok;
  logic waddr_ok;

  assign raddr_ok = ({1'b0, raddr} < (ACCT_W+1)'(NUM_ACCT));
  assign waddr_ok = ({1'b0, waddr} < (ACCT_W+1)'(NUM_ACCT));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        mem[i] <= INIT_ENTRY;
      end
    end else if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return a clean entry; the FSM rejects those accounts anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= INIT_ENTRY;
    end else if (raddr_ok) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= INIT_ENTRY;
    end
  end

endmodule

// File: rtl/atm_bank_responder.sv
// Bank-side responder: accepts one account request at a time, checks it
// against the account table and returns a status plus resulting balance.
module atm_bank_responder
  import atm_bank_pkg::*;
#(
  parameter int               NUM_ACCT    = DEF_NUM_ACCT,
  parameter logic [BAL_W-1:0] INIT_BAL    = DEF_INIT_BAL,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = DEF_DEFAULT_PIN,
  parameter int               MAX_TRIES   = DEF_MAX_TRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [BAL_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_balance,
  output logic              busy
);

  state_e state;
  state_e next_state;

  logic [2:0]        op_q;
  logic [ACCT_W-1:0] acct_q;
  logic [PIN_W-1:0]  pin_q;
  logic [BAL_W-1:0]  amount_q;

  acct_entry_t entry;
  acct_entry_t exec_entry;
  logic        exec_we;
  status_e     exec_status;
  logic [BAL_W-1:0] exec_balance;
  logic [BAL_W:0]   sum;

  status_e          status_q;
  logic [BAL_W-1:0] balance_q;

  atm_acct_table #(
    .NUM_ACCT    (NUM_ACCT),
    .INIT_BAL    (INIT_BAL),
    .DEFAULT_PIN (DEFAULT_PIN)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .raddr (acct_q),
    .rdata (entry),
    .we    (exec_we && (state == EXEC)),
    .waddr (acct_q),
    .wdata (exec_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = LOOKUP;
      LOOKUP:  next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The request is captured only on acceptance so later input wiggles are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      acct_q   <= '0;
      pin_q    <= '0;
      amount_q <= '0;
    end else if (state == IDLE && req_valid) begin
      op_q     <= req_op;
      acct_q   <= req_acct;
      pin_q    <= req_pin;
      amount_q <= req_amount;
    end
  end

  assign sum = {1'b0, entry.balance} + {1'b0, amount_q};

  // Checks in priority order; the first three leave the entry untouched.
  always_comb begin
    exec_entry   = entry;
    exec_we      = 1'b0;
    exec_status  = ST_OK;
    exec_balance = '0;
    if ({1'b0, acct_q} >= (ACCT_W+1)'(NUM_ACCT)) begin
      exec_status = ST_BAD_ACCT;
    end else if (op_q > OP_CHANGE_PIN) begin
      exec_status = ST_BAD_OP;
    end else if (entry.locked) begin
      exec_status = ST_LOCKED;
    end else if (pin_q != entry.pin) begin
      exec_status      = ST_BAD_PIN;
      exec_we          = 1'b1;
      exec_entry.fails = entry.fails + FAIL_W'(1);
      if (exec_entry.fails == FAIL_W'(MAX_TRIES)) begin
        exec_entry.locked = 1'b1;
      end
    end else begin
      exec_we          = 1'b1;
      exec_entry.fails = '0;
      case (op_q)
        OP_WITHDRAW: begin
          if (amount_q > entry.balance) begin
            exec_status = ST_INSUFFICIENT;
          end else begin
            exec_entry.balance = entry.balance - amount_q;
            exec_balance       = entry.balance - amount_q;
          end
        end
        OP_DEPOSIT: begin
          if (sum[BAL_W]) begin
            exec_status = ST_OVERFLOW;
          end else begin
            exec_entry.balance = sum[BAL_W-1:0];
            exec_balance       = sum[BAL_W-1:0];
          end
        end
        OP_CHANGE_PIN: begin
          exec_entry.pin = amount_q[PIN_W-1:0];
          exec_balance   = entry.balance;
        end
        default: begin
          exec_balance = entry.balance;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= ST_OK;
      balance_q <= '0;
    end else if (state == EXEC) begin
      status_q  <= exec_status;
      balance_q <= exec_balance;
    end
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);
  assign rsp_status  = status_q;
  assign rsp_balance = balance_q;

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed bench for atm_bank_responder: table-driven transactions per feature
// with hand-computed status and balance expectations.
module tb_atm_bank_responder;
  import atm_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [4:0] req_acct;
  logic [3:0] req_pin;
  logic [7:0] req_amount;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_status;
  logic [7:0] rsp_balance;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] op;
    logic [4:0] acct;
    logic [3:0] pin;
    logic [7:0] amt;
    logic [2:0] st;
    logic [7:0] bal;
  } vec_t;

  atm_bank_responder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_acct    (req_acct),
    .req_pin     (req_pin),
    .req_amount  (req_amount),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request from a negedge, scrambles the inputs after acceptance
  // and returns the response fields plus the accept-to-rsp_valid latency.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] acct,
                               input logic [3:0] pin, input logic [7:0] amt,
                               output logic [2:0] st, output logic [7:0] bal,
                               output int lat);
    logic got;
    req_op = op; req_acct = acct; req_pin = pin; req_amount = amt;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    n_assert++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_timeout: req_ready got %b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'd7; req_acct = ~acct; req_pin = ~pin; req_amount = ~amt;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL rsp_timeout: rsp_valid got 0 want 1");
    end
    st  = rsp_status;
    bal = rsp_balance;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({req_ready, rsp_valid, rsp_status, rsp_balance, busy} !== {1'b1, 1'b0, 3'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b st=%0d bal=%0d busy=%b want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_status, rsp_balance, busy);
    end
  endtask

  task automatic test_withdraw();
    vec_t v[5];
    logic [2:0] st; logic [7:0] bal; int lat;
    v[0] = '{OP_BALANCE,  5'd3, 4'hF, 8'd0,  ST_OK,           8'd50};
    v[1] = '{OP_WITHDRAW, 5'd3, 4'hF, 8'd20, ST_OK,           8'd30};
    v[2] = '{OP_WITHDRAW, 5'd3, 4'hF, 8'd31, ST_INSUFFICIENT, 8'd0};
    v[3] = '{OP_BALANCE,  5'd3, 4'hF, 8'd0,  ST_OK,           8'd30};
    v[4] = '{OP_WITHDRAW, 5'd3, 4'hF, 8'd30, ST_OK,           8'd0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(v[i].op, v[i].acct, v[i].pin, v[i].amt, st, bal, lat);
      n_assert++;
      if (st !== v[i].st || bal !== v[i].bal) begin
        n_fail++;
        $display("[TB] FAIL withdraw[%0d]: status %0d bal %0d, want %0d bal %0d", i, st, bal, v[i].st, v[i].bal);
      end
      if (i == 0) begin
        n_assert++;
        if (lat !== 3) begin
          n_fail++;
          $display("[TB] FAIL latency: got %0d want 3", lat);
        end
      end
    end
  endtask

  task automatic test_deposit();
    vec_t v[4];
    logic [2:0] st; logic [7:0] bal; int lat;
    v[0] = '{OP_DEPOSIT, 5'd5, 4'hF, 8'd205, ST_OK,       8'd255};
    v[1] = '{OP_DEPOSIT, 5'd5, 4'hF, 8'd1,   ST_OVERFLOW, 8'd0};
    v[2] = '{OP_BALANCE, 5'd5, 4'hF, 8'd0,   ST_OK,       8'd255};
    v[3] = '{OP_DEPOSIT, 5'd5, 4'hF, 8'd0,   ST_OK,       8'd255};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[i].op, v[i].acct, v[i].pin, v[i].amt, st, bal, lat);
      n_assert++;
      if (st !== v[i].st || bal !== v[i].bal) begin
        n_fail++;
        $display("[TB] FAIL deposit[%0d]: status %0d bal %0d, want %0d bal %0d", i, st, bal, v[i].st, v[i].bal);
      end
    end
  endtask

  task automatic test_lockout();
    vec_t v[5];
    logic [2:0] st; logic [7:0] bal; int lat;
    v[0] = '{OP_VERIFY,  5'd7, 4'h0, 8'd0, ST_BAD_PIN, 8'd0};
    v[1] = '{OP_VERIFY,  5'd7, 4'h0, 8'd0, ST_BAD_PIN, 8'd0};
    v[2] = '{OP_VERIFY,  5'd7, 4'h0, 8'd0, ST_BAD_PIN, 8'd0};
    v[3] = '{OP_VERIFY,  5'd7, 4'hF, 8'd0, ST_LOCKED,  8'd0};
    v[4] = '{OP_BALANCE, 5'd7, 4'h0, 8'd0, ST_LOCKED,  8'd0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(v[i].op, v[i].acct, v[i].pin, v[i].amt, st, bal, lat);
      n_assert++;
      if (st !== v[i].st || bal !== v[i].bal) begin
        n_fail++;
        $display("[TB] FAIL lockout[%0d]: status %0d bal %0d, want %0d bal %0d", i, st, bal, v[i].st, v[i].bal);
      end
    end
    do_reset();
    applyStimulus(OP_VERIFY, 5'd7, 4'hF, 8'd0, st, bal, lat);
    n_assert++;
    if (st !== ST_OK || bal !== 8'd50) begin
      n_fail++;
      $display("[TB] FAIL unlock_by_reset: status %0d bal %0d, want 0 bal 50", st, bal);
    end
  endtask

  task automatic test_pin_change();
    vec_t v[8];
    logic [2:0] st; logic [7:0] bal; int lat;
    v[0] = '{OP_VERIFY,     5'd9, 4'h0, 8'd0,  ST_BAD_PIN, 8'd0};
    v[1] = '{OP_VERIFY,     5'd9, 4'hF, 8'd0,  ST_OK,      8'd50};
    v[2] = '{OP_VERIFY,     5'd9, 4'h0, 8'd0,  ST_BAD_PIN, 8'd0};
    v[3] = '{OP_VERIFY,     5'd9, 4'h0, 8'd0,  ST_BAD_PIN, 8'd0};
    v[4] = '{OP_VERIFY,     5'd9, 4'hF, 8'd0,  ST_OK,      8'd50};
    v[5] = '{OP_CHANGE_PIN, 5'd9, 4'hF, 8'h05, ST_OK,      8'd50};
    v[6] = '{OP_VERIFY,     5'd9, 4'hF, 8'd0,  ST_BAD_PIN, 8'd0};
    v[7] = '{OP_VERIFY,     5'd9, 4'h5, 8'd0,  ST_OK,      8'd50};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(v[i].op, v[i].acct, v[i].pin, v[i].amt, st, bal, lat);
      n_assert++;
      if (st !== v[i].st || bal !== v[i].bal) begin
        n_fail++;
        $display("[TB] FAIL pin_change[%0d]: status %0d bal %0d, want %0d bal %0d", i, st, bal, v[i].st, v[i].bal);
      end
    end
  endtask

  // Wrong PINs on illegal ops must not count toward the lockout.
  task automatic test_bad_op();
    vec_t v[4];
    logic [2:0] st; logic [7:0] bal; int lat;
    v[0] = '{3'd6, 5'd3, 4'h0, 8'd0, ST_BAD_OP, 8'd0};
    v[1] = '{3'd5, 5'd3, 4'h0, 8'd0, ST_BAD_OP, 8'd0};
    v[2] = '{3'd7, 5'd3, 4'h0, 8'd0, ST_BAD_OP, 8'd0};
    v[3] = '{OP_VERIFY, 5'd3, 4'hF, 8'd0, ST_OK, 8'd50};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[i].op, v[i].acct, v[i].pin, v[i].amt, st, bal, lat);
      n_assert++;
      if (st !== v[i].st || bal !== v[i].bal) begin
        n_fail++;
        $display("[TB] FAIL bad_op[%0d]: status %0d bal %0d, want %0d bal %0d", i, st, bal, v[i].st, v[i].bal);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] st; logic [7:0] bal; int lat;
    rsp_ready = 1'b0;
    applyStimulus(OP_BALANCE, 5'd3, 4'hF, 8'd0, st, bal, lat);
    for (int i = 0; i < 5; i++) begin
      n_assert++;
      if ({rsp_valid, rsp_status, rsp_balance, req_ready, busy} !== {1'b1, 3'd0, 8'd50, 1'b0, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL hold[%0d]: vld=%b st=%0d bal=%0d rdy=%b busy=%b want 1 0 50 0 1",
                 i, rsp_valid, rsp_status, rsp_balance, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL release: vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    req_op = OP_BALANCE; req_acct = 5'd11; req_pin = 4'hF; req_amount = 8'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) accepts++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_assert++;
    if (accepts !== 3) begin
      n_fail++;
      $display("[TB] FAIL back_to_back: accepts got %0d want 3", accepts);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    logic [2:0] st; logic [7:0] bal; int lat;
    logic seen_rsp = 1'b0;
    req_op = OP_DEPOSIT; req_acct = 5'd12; req_pin = 4'hF; req_amount = 8'd10;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_exec_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || busy) seen_rsp = 1'b1;
      @(negedge clk);
    end
    n_assert++;
    if (seen_rsp !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_rsp: activity got %b want 0", seen_rsp);
    end
    applyStimulus(OP_BALANCE, 5'd12, 4'hF, 8'd0, st, bal, lat);
    n_assert++;
    if (st !== ST_OK || bal !== 8'd50) begin
      n_fail++;
      $display("[TB] FAIL abort_balance: status %0d bal %0d, want 0 bal 50", st, bal);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_acct = '0; req_pin = '0;
    req_amount = '0; rsp_ready = 1'b1;
    test_reset();
    test_withdraw();
    test_deposit();
    test_lockout();
    test_pin_change();
    test_bad_op();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
